// File: rtl/cla_pkg.sv
// Shared definitions for the carry-lookahead adder slice: segment width,
// segment vector type and the per-bit generate/propagate helper.
package cla_pkg;

  localparam int SEG = 16;

  typedef logic [SEG-1:0] seg_t;

  typedef struct packed {
    seg_t g;
    seg_t p;
  } gp_t;

  function automatic gp_t calc_gp(input seg_t a, input seg_t b);
    gp_t r;
    r.g = a & b;
    r.p = a ^ b;
    return r;
  endfunction

endpackage

// File: rtl/cla_gcout16.sv
// 16-bit group carry-out: two-level lookahead over four 4-bit groups,
// producing the carry out of bit 15 from (cin, g, p).
module cla_gcout16
  import cla_pkg::*;
(
  input  logic cin,
  input  seg_t g,
  input  seg_t p,
  output logic Cout
);

  logic [3:0] gg;
  logic [3:0] pg;

  always_comb begin
    gg = '0;
    pg = '0;
    for (int j = 0; j < 4; j++) begin
      gg[j] = g[4*j+3]
            | (p[4*j+3] & g[4*j+2])
            | (p[4*j+3] & p[4*j+2] & g[4*j+1])
            | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
      pg[j] = &p[4*j +: 4];
    end
  end

  assign Cout = gg[3]
              | (pg[3] & gg[2])
              | (pg[3] & pg[2] & gg[1])
              | (pg[3] & pg[2] & pg[1] & gg[0])
              | ((&pg) & cin);

endmodule

// File: rtl/cla_seg16.sv
// Combinational 16-bit adder segment: bit sums from the carry chain,
// segment carry-out from the group carry-out block.
module cla_seg16
  import cla_pkg::*;
(
  input  logic cin,
  input  seg_t a,
  input  seg_t b,
  output seg_t s,
  output logic cout
);

  gp_t gp;

  assign gp = calc_gp(a, b);

  always_comb begin
    logic cy;
    cy = cin;
    s  = '0;
    for (int i = 0; i < SEG; i++) begin
      s[i] = gp.p[i] ^ cy;
      cy   = gp.g[i] | (gp.p[i] & cy);
    end
  end

  cla_gcout16 u_gcout (
    .cin  (cin),
    .g    (gp.g),
    .p    (gp.p),
    .Cout (cout)
  );

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined wide adder: one 16-bit segment resolved per stage, with the
// inter-segment carry registered. WIDTH must be a multiple of SEG.
module cla_pipe_adder #(
  parameter int WIDTH = 64,
  parameter int SEG   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  import cla_pkg::*;

  localparam int STAGES = WIDTH / SEG;

  logic adv;

  assign adv      = !out_valid | out_ready;
  assign in_ready = adv;

  // Stage k keeps a word whose low k segments are resolved sum and whose
  // upper segments are still raw operand A; operand B shrinks as it is consumed.
  for (genvar k = 0; k < STAGES; k++) begin : stg
    localparam int OPW = WIDTH - k*SEG;

    logic             vld, vld_in;
    logic             carry, carry_in, c_nxt;
    logic [WIDTH-1:0] w, w_in, w_nxt;
    logic [OPW-1:0]   bo, bo_in;
    seg_t             s;

    if (k == 0) begin : g_src
      assign vld_in   = in_valid;
      assign carry_in = cin;
      assign w_in     = a;
      assign bo_in    = b;
    end else begin : g_src
      assign vld_in   = stg[k-1].vld;
      assign carry_in = stg[k-1].c_nxt;
      assign w_in     = stg[k-1].w_nxt;
      assign bo_in    = stg[k-1].bo[OPW+SEG-1:SEG];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld   <= 1'b0;
        carry <= 1'b0;
        w     <= '0;
        bo    <= '0;
      end else if (adv) begin
        vld   <= vld_in;
        carry <= carry_in;
        w     <= w_in;
        bo    <= bo_in;
      end
    end

    cla_seg16 u_seg (
      .cin  (carry),
      .a    (w[k*SEG +: SEG]),
      .b    (bo[SEG-1:0]),
      .s    (s),
      .cout (c_nxt)
    );

    always_comb begin
      w_nxt = w;
      w_nxt[k*SEG +: SEG] = s;
    end
  end

  // Output slot: fully resolved sum and final carry, registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
    end else if (adv) begin
      out_valid <= stg[STAGES-1].vld;
      sum       <= stg[STAGES-1].w_nxt;
      cout      <= stg[STAGES-1].c_nxt;
    end
  end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed self-checking bench for cla_pipe_adder: reset, ripple, streaming,
// backpressure, bubbles and mid-flight reset.
module tb_cla_pipe_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] a;
  logic [63:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] sum;
  logic        cout;

  int checks = 0;
  int errors = 0;
  int n_out;
  int cyc = 0;
  int first_cyc;
  int last_cyc;
  logic acc;
  logic [64:0] exp_q[$];

  cla_pipe_adder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation did not reach its end");
    $fatal(1, "[TB] timeout");
  end

  task automatic check(input string tag, input logic [64:0] got, input logic [64:0] expv);
    checks++;
    assert (got === expv) else begin
      errors++;
      $error("[TB] FAIL %s: got %h expected %h", tag, got, expv);
    end
  endtask

  // One cycle: drive inputs, score any output transfer, then cross the edge.
  task automatic step(input logic iv, input logic [63:0] ia, input logic [63:0] ib,
                      input logic icin, input logic ordy, input logic [64:0] iexp,
                      output logic accepted);
    in_valid  = iv;
    a         = ia;
    b         = ib;
    cin       = icin;
    out_ready = ordy;
    #1;
    accepted = iv & in_ready;
    if (out_valid && ordy) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("[TB] FAIL unexpected_output: got sum %h with no item pending, expected none", sum);
      end
      if (exp_q.size() > 0) begin
        check("result", {cout, sum}, exp_q.pop_front());
        if (n_out == 0) first_cyc = cyc;
        last_cyc = cyc;
        n_out++;
      end
    end
    if (accepted) exp_q.push_back(iexp);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain(input int n);
    for (int j = 0; j < n; j++) step(1'b0, '0, '0, 1'b0, 1'b1, '0, acc);
  endtask

  initial begin
    logic [63:0] bv;
    logic [63:0] av;
    logic [63:0] held;
    int idx;
    bit stall_done;

    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;

    // Reset
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", {64'b0, out_valid}, 65'd0);
    rst_n = 1'b1;
    #1;
    check("reset_out_valid_after", {64'b0, out_valid}, 65'd0);
    check("reset_sum", {cout, sum}, 65'd0);
    check("reset_in_ready", {64'b0, in_ready}, 65'd1);
    @(posedge clk);
    #1;

    // Full ripple across all segments
    n_out = 0;
    step(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b1, 65'h1_0000_0000_0000_0000, acc);
    check("ripple_accept", {64'b0, acc}, 65'd1);
    for (int j = 0; j < 4; j++) begin
      check("ripple_latency_low", {64'b0, out_valid}, 65'd0);
      step(1'b0, '0, '0, 1'b0, 1'b1, '0, acc);
    end
    check("ripple_valid", {64'b0, out_valid}, 65'd1);
    check("ripple_sum", {cout, sum}, 65'h1_0000_0000_0000_0000);
    step(1'b0, '0, '0, 1'b0, 1'b1, '0, acc);
    check("ripple_one_cycle", {64'b0, out_valid}, 65'd0);
    check("ripple_count", 65'(n_out), 65'd1);

    // Back-to-back streaming
    n_out = 0;
    bv = 64'h0000_0001_0000_FFFF;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 64'(i), bv, 1'b0, 1'b1, {1'b0, bv + 64'(i)}, acc);
      check("stream_accept", {64'b0, acc}, 65'd1);
    end
    drain(8);
    check("stream_count", 65'(n_out), 65'd16);
    check("stream_consecutive", 65'(last_cyc - first_cyc), 65'd15);
    check("stream_queue_empty", 65'(exp_q.size()), 65'd0);

    // Backpressure: freeze for 5 cycles once a result is presented
    n_out = 0;
    idx = 0;
    stall_done = 1'b0;
    bv = 64'h0001_FFFF_0001_FFFF;
    for (int c = 0; c < 60 && n_out < 8; c++) begin
      av = 64'hFFFF_0000_FFFF_0000 + 64'(idx);
      if (!stall_done && out_valid) begin
        held = sum;
        for (int j = 0; j < 5; j++) begin
          step(idx < 8, av, bv, idx[0], 1'b0, '0, acc);
          check("bp_no_accept", {64'b0, acc}, 65'd0);
          check("bp_in_ready", {64'b0, in_ready}, 65'd0);
          check("bp_sum_stable", {1'b0, sum}, {1'b0, held});
        end
        stall_done = 1'b1;
      end else begin
        step(idx < 8, av, bv, idx[0], 1'b1, {1'b0, av} + {1'b0, bv} + 65'(idx[0]), acc);
        if (acc) idx++;
      end
    end
    check("bp_sent", 65'(idx), 65'd8);
    check("bp_count", 65'(n_out), 65'd8);
    check("bp_queue_empty", 65'(exp_q.size()), 65'd0);

    // Bubbles: valid on alternate cycles, results emerge with gaps
    n_out = 0;
    for (int s = 0; s < 12; s++) begin
      check("bubble_out_valid", {64'b0, out_valid},
            {64'b0, (s >= 5 && s <= 9 && ((s - 5) % 2 == 0))});
      step((s < 6) && (s % 2 == 0), 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
           1'b0, 1'b1, 65'h1_0000_0000_0000_0000, acc);
    end
    check("bubble_count", 65'(n_out), 65'd3);

    // Mid-flight reset
    for (int i = 0; i < 3; i++)
      step(1'b1, 64'(i + 5), 64'h1, 1'b0, 1'b1, 65'(i + 6), acc);
    step(1'b0, '0, '0, 1'b0, 1'b0, '0, acc);
    step(1'b0, '0, '0, 1'b0, 1'b0, '0, acc);
    check("midrst_pre_valid", {64'b0, out_valid}, 65'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_drop", {64'b0, out_valid}, 65'd0);
    check("midrst_sum_clear", {cout, sum}, 65'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    n_out = 0;
    for (int j = 0; j < 6; j++) begin
      check("midrst_no_stale", {64'b0, out_valid}, 65'd0);
      step(1'b0, '0, '0, 1'b0, 1'b1, '0, acc);
    end
    step(1'b1, 64'h0000_0000_0000_FFFF, 64'h0000_0000_FFFF_0000, 1'b1, 1'b1,
         65'h0_0000_0001_0000_0000, acc);
    check("midrst_accept", {64'b0, acc}, 65'd1);
    for (int j = 0; j < 4; j++) begin
      check("midrst_latency_low", {64'b0, out_valid}, 65'd0);
      step(1'b0, '0, '0, 1'b0, 1'b1, '0, acc);
    end
    check("midrst_valid", {64'b0, out_valid}, 65'd1);
    step(1'b0, '0, '0, 1'b0, 1'b1, '0, acc);
    check("midrst_count", 65'(n_out), 65'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cla_pipe_adder.md
# cla_pipe_adder

Pipelined wide adder built from 16-bit carry-lookahead segments, one segment resolved per pipeline stage, with the inter-segment carry registered between stages. It sits directly downstream of the 16-bit group carry-out logic and consumes that logic's `Cout` to chain segments. The block accepts one operand pair per cycle through a valid/ready handshake and returns the full-width sum and final carry STAGES cycles later.

## Interface
- `WIDTH`, default 64: operand and sum width; must be a multiple of `SEG`.
- `SEG`, default 16: segment width resolved per stage. It is fixed at 16 to match the group carry-out block.
- Derived constant `STAGES = WIDTH/SEG`, default 4.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operand pair present.
- `in_ready`  out  1  block can accept the operand pair this cycle.
- `a`  in  WIDTH  operand A.
- `b`  in  WIDTH  operand B.
- `cin`  in  1  carry into bit 0.
- `out_valid`  out  1  `sum`/`cout` hold a valid result.
- `out_ready`  in  1  consumer accepts the result.
- `sum`  out  WIDTH  (a + b + cin) mod 2^WIDTH.
- `cout`  out  1  carry out of bit WIDTH-1.

## Operation
- Global advance: `adv = !out_valid | out_ready`; `in_ready = adv`. Every stage register loads on `adv` and holds otherwise.
- Transfer rules:
  - An input transfer occurs when `in_valid & in_ready`.
  - An output transfer occurs when `out_valid & out_ready`.
- Stage k (k = 0..STAGES-1) holds:
  - a valid bit,
  - the registered carry into segment k,
  - the sum segments 0..k-1 already resolved,
  - the raw operand segments k..STAGES-1, which are delayed unmodified.
- Stage 0 takes `cin` as its carry and `a`/`b` from the inputs.
- Per segment logic:
  - g[i] = a[i] & b[i]; p[i] = a[i] ^ b[i].
  - Bit carries: c[0] = carry-in, c[i+1] = g[i] | p[i]&c[i].
  - sum[i] = p[i] ^ c[i].
  - Segment carry-out comes from the 16-bit group carry-out function of (carry-in, g, p) and is registered into the next stage.
- The last stage drives `sum`, `cout` and `out_valid` directly from its registers. No combinational path runs from `a`/`b`/`cin` to the outputs.
- Bubbles: a stage whose input valid bit is 0 loads valid=0. Its data registers are don't-care and may load.
- Backpressure: while `out_valid & !out_ready`, the whole pipe freezes and `in_ready = 0`. Bubbles are compressed only while the output slot is empty.

## Timing
- Reset (async assert, sync-safe deassert) clears:
  - all valid bits, so `out_valid = 0`;
  - `sum = 0`, `cout = 0`, and all carry and data registers to 0.
- `in_ready` is 1 out of reset.
- Latency: an input accepted at edge N appears with `out_valid = 1` after edge N+STAGES−1+1. That is STAGES cycles, 4 by default, when there is no stall.
- Throughput: one result per cycle while `out_ready` is held at 1.
- Stall: each cycle with `adv = 0` adds exactly one cycle of latency to every item in flight. Data held under stall must not change.
- `in_valid` deasserted while `in_ready = 1` inserts a bubble. Data inputs are ignored when `in_valid = 0`.
- Reset asserted mid-operation discards all in-flight items, with no partial result. `out_valid` falls asynchronously with `rst_n`.
- Carry chaining: a carry generated in segment k affects segment k+1 exactly one stage later. There is no same-cycle ripple across stages.

## Structure
- Shared package `cla_pkg` holds:
  - `SEG = 16`;
  - the helper function computing per-bit g/p;
  - a `seg_t` typedef for a 16-bit logic vector.
- Sub-module `cla_seg16` is combinational.
  - Inputs: `cin`, `a[15:0]`, `b[15:0]`.
  - Outputs: `s[15:0]`, `cout`.
  - It uses the existing 16-bit group carry-out block for `cout`.
  - It is instantiated STAGES times, once per stage. All registering lives in `cla_pipe_adder`.

## Test plan
- Reset: hold `rst_n = 0` for 3 cycles, then release. Required: `out_valid = 0`, `sum = 0`, `cout = 0`, `in_ready = 1`.
- Full ripple: a = 64'hFFFF_FFFF_FFFF_FFFF, b = 0, cin = 1, `out_ready = 1`. Required: 4 cycles later, `sum = 0`, `cout = 1`, `out_valid` high for exactly one cycle.
- Back-to-back streaming: send a = i, b = 64'h0000_0001_0000_FFFF for i = 0..15, `in_valid` continuous. Required: 16 consecutive results, in order, each equal to i + b with `cout = 0`.
- Backpressure: stream 8 items and drop `out_ready` for 5 cycles once `out_valid` is up. Required:
  - `in_ready = 0` and `sum` stable during the 5 cycles;
  - no item lost or duplicated;
  - results in order.
- Bubbles: alternate `in_valid` 1/0 with a = 64'h8000_0000_0000_0000, b = 64'h8000_0000_0000_0000. Required: `sum = 0` and `cout = 1` on alternate cycles, with `out_valid = 0` between them.
- Mid-flight reset: accept 3 items, assert `rst_n = 0` for one cycle on the 2nd cycle. Required: `out_valid` drops immediately, no stale result emerges afterwards, and the next item is returned after 4 cycles.
